// File: rtl/ysyx_22041752_div_ctrl_pkg.sv
// Shared definitions for the divider control block: data width, op-field
// bit positions, FSM encoding and the 32->64 extension helper.
package ysyx_22041752_div_ctrl_pkg;

   localparam int RF_DATA_WD = 64;
   localparam int OP_WD      = 3;

   // req_op = {word, signed_n, rem}; signed_n = 1 means unsigned
   localparam int OP_WORD = 2;
   localparam int OP_UNS  = 1;
   localparam int OP_REM  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // Extend a 32-bit value to the full data width, sign or zero.
   function automatic logic [RF_DATA_WD-1:0] ext32(input logic [31:0] v,
                                                   input logic        sgn);
      ext32 = {{(RF_DATA_WD-32){sgn & v[31]}}, v};
   endfunction

endpackage

// File: rtl/ysyx_22041752_div_opnd_prep.sv
// Combinational operand preparation (word extension) for the divider and
// result selection / word sign-extension for the response.
module ysyx_22041752_div_opnd_prep
   import ysyx_22041752_div_ctrl_pkg::*;
(
   input  logic                  prep_word,
   input  logic                  prep_uns,
   input  logic [RF_DATA_WD-1:0] src1,
   input  logic [RF_DATA_WD-1:0] src2,
   output logic [RF_DATA_WD-1:0] dividend,
   output logic [RF_DATA_WD-1:0] divisor,
   input  logic                  sel_word,
   input  logic                  sel_rem,
   input  logic [RF_DATA_WD-1:0] quotient,
   input  logic [RF_DATA_WD-1:0] remainder,
   output logic [RF_DATA_WD-1:0] resp_data
);

   logic [RF_DATA_WD-1:0] selected;

   // Word ops divide the low halves, extended according to signedness.
   assign dividend = prep_word ? ext32(src1[31:0], ~prep_uns) : src1;
   assign divisor  = prep_word ? ext32(src2[31:0], ~prep_uns) : src2;

   // Word results are always sign-extended, even for the unsigned variants.
   assign selected  = sel_rem ? remainder : quotient;
   assign resp_data = sel_word ? ext32(selected[31:0], 1'b1) : selected;

endmodule

// File: rtl/ysyx_22041752_div_ctrl.sv
// Divider controller: accepts pipeline divide requests, drives an external
// iterative divider, and short-circuits DIV-then-REM pairs via a one-entry
// result cache.
module ysyx_22041752_div_ctrl
   import ysyx_22041752_div_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OP_WD-1:0]      req_op,
   input  logic [RF_DATA_WD-1:0] req_src1,
   input  logic [RF_DATA_WD-1:0] req_src2,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [RF_DATA_WD-1:0] resp_data,
   input  logic                  flush,
   output logic                  dv_valid,
   output logic [RF_DATA_WD-1:0] dv_dividend,
   output logic [RF_DATA_WD-1:0] dv_divisor,
   output logic                  dv_signed,
   output logic                  dv_flush,
   input  logic                  dv_out_valid,
   input  logic [RF_DATA_WD-1:0] dv_quotient,
   input  logic [RF_DATA_WD-1:0] dv_remainder
);

   div_state_e state_reg, state_next;

   // Latched copy of the accepted request (prepared operands)
   logic                  word_reg, rem_reg, signed_reg;
   logic [RF_DATA_WD-1:0] dividend_reg, divisor_reg;

   // One-entry cache; its quotient/remainder also serve as the result
   // registers, since a hit reloads exactly the same values.
   logic                  cache_vld_reg, cache_signed_reg, cache_word_reg;
   logic [RF_DATA_WD-1:0] cache_dividend_reg, cache_divisor_reg;
   logic [RF_DATA_WD-1:0] cache_quot_reg, cache_rem_reg;

   logic [RF_DATA_WD-1:0] prep_dividend, prep_divisor;
   logic                  req_signed, cache_hit, accept, capture;

   ysyx_22041752_div_opnd_prep u_prep (
      .prep_word (req_op[OP_WORD]),
      .prep_uns  (req_op[OP_UNS]),
      .src1      (req_src1),
      .src2      (req_src2),
      .dividend  (prep_dividend),
      .divisor   (prep_divisor),
      .sel_word  (word_reg),
      .sel_rem   (rem_reg),
      .quotient  (cache_quot_reg),
      .remainder (cache_rem_reg),
      .resp_data (resp_data)
   );

   assign req_signed = ~req_op[OP_UNS];
   assign cache_hit  = cache_vld_reg
                     && (prep_dividend   == cache_dividend_reg)
                     && (prep_divisor    == cache_divisor_reg)
                     && (req_signed      == cache_signed_reg)
                     && (req_op[OP_WORD] == cache_word_reg);
   assign accept  = (state_reg == ST_IDLE) && req_valid && !flush;
   assign capture = (state_reg == ST_BUSY) && dv_out_valid && !flush;

   assign dv_dividend = dividend_reg;
   assign dv_divisor  = divisor_reg;
   assign dv_signed   = signed_reg;

   // Next-state and handshake outputs; flush overrides everything.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      dv_valid   = 1'b0;
      dv_flush   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            req_ready = !flush;
            if (accept)
               state_next = cache_hit ? ST_DONE : ST_BUSY;
         end
         ST_BUSY: begin
            dv_valid = !flush;
            dv_flush = flush;
            if (flush)
               state_next = ST_IDLE;
            else if (dv_out_valid)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            resp_valid = !flush;
            if (flush || resp_ready)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, request latch and cache/result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= ST_IDLE;
         word_reg           <= 1'b0;
         rem_reg            <= 1'b0;
         signed_reg         <= 1'b0;
         dividend_reg       <= '0;
         divisor_reg        <= '0;
         cache_vld_reg      <= 1'b0;
         cache_signed_reg   <= 1'b0;
         cache_word_reg     <= 1'b0;
         cache_dividend_reg <= '0;
         cache_divisor_reg  <= '0;
         cache_quot_reg     <= '0;
         cache_rem_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            word_reg     <= req_op[OP_WORD];
            rem_reg      <= req_op[OP_REM];
            signed_reg   <= req_signed;
            dividend_reg <= prep_dividend;
            divisor_reg  <= prep_divisor;
         end
         if (capture) begin
            cache_vld_reg      <= 1'b1;
            cache_signed_reg   <= signed_reg;
            cache_word_reg     <= word_reg;
            cache_dividend_reg <= dividend_reg;
            cache_divisor_reg  <= divisor_reg;
            cache_quot_reg     <= dv_quotient;
            cache_rem_reg      <= dv_remainder;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22041752_div_ctrl.sv
// Directed bench for the divider controller; the divider is modelled by the
// bench returning hand-computed quotient/remainder after a per-vector latency.
module tb_ysyx_22041752_div_ctrl;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, resp_valid, resp_ready, flush;
   logic [2:0]  req_op;
   logic [63:0] req_src1, req_src2, resp_data;
   logic        dv_valid, dv_signed, dv_flush, dv_out_valid;
   logic [63:0] dv_dividend, dv_divisor, dv_quotient, dv_remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22041752_div_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .flush(flush),
      .dv_valid(dv_valid), .dv_dividend(dv_dividend), .dv_divisor(dv_divisor),
      .dv_signed(dv_signed), .dv_flush(dv_flush), .dv_out_valid(dv_out_valid),
      .dv_quotient(dv_quotient), .dv_remainder(dv_remainder)
   );

   typedef struct {
      logic [2:0]  op;
      logic [63:0] s1, s2, dvd, dvs;
      logic        sgn;
      logic [63:0] q, r;
      int          lat;
      logic        hit;
      int          stall;
      logic [63:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] op, input logic [63:0] s1, s2,
                               input logic [63:0] dvd, dvs, input logic sgn,
                               input logic [63:0] q, r, input int lat,
                               input logic hit, input int stall,
                               input logic [63:0] exp);
      vec_t v;
      v.op = op; v.s1 = s1; v.s2 = s2; v.dvd = dvd; v.dvs = dvs; v.sgn = sgn;
      v.q = q; v.r = r; v.lat = lat; v.hit = hit; v.stall = stall; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One full request/response transaction; called at a negedge in IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_op = v.op; req_src1 = v.s1; req_src2 = v.s2;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (v.hit) begin
         chk("hit_resp_valid", {63'd0, resp_valid}, 64'd1);
         chk("hit_no_dv_valid", {63'd0, dv_valid}, 64'd0);
      end else begin
         chk("busy_dv_valid", {63'd0, dv_valid}, 64'd1);
         chk("busy_dividend", dv_dividend, v.dvd);
         chk("busy_divisor", dv_divisor, v.dvs);
         chk("busy_signed", {63'd0, dv_signed}, {63'd0, v.sgn});
         chk("busy_req_ready", {63'd0, req_ready}, 64'd0);
         repeat (v.lat - 1) @(negedge clk);
         chk("busy_no_resp", {63'd0, resp_valid}, 64'd0);
         dv_out_valid = 1'b1; dv_quotient = v.q; dv_remainder = v.r;
         @(negedge clk);
         dv_out_valid = 1'b0; dv_quotient = '0; dv_remainder = '0;
         #1;
         chk("dv_low_after_cap", {63'd0, dv_valid}, 64'd0);
         chk("done_resp_valid", {63'd0, resp_valid}, 64'd1);
      end
      chk("resp_data", resp_data, v.exp);
      for (int i = 0; i < v.stall; i++) begin
         @(negedge clk);
         #1;
         chk("stall_resp_data", resp_data, v.exp);
         chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
         chk("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
      end
      $display("vec %0d op=%b src1=%h src2=%h hit=%0d data=%h", idx, v.op, v.s1, v.s2, v.hit, resp_data);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk("back_idle_ready", {63'd0, req_ready}, 64'd1);
      chk("back_idle_resp", {63'd0, resp_valid}, 64'd0);
   endtask

   // Issue a request for one cycle without completing it.
   task automatic start_req(input logic [2:0] op, input logic [63:0] s1, s2);
      req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      chk({nm, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
      chk({nm, "_dv_valid"}, {63'd0, dv_valid}, 64'd0);
      chk({nm, "_dv_flush"}, {63'd0, dv_flush}, 64'd0);
      chk({nm, "_resp_data"}, resp_data, 64'd0);
   endtask

   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
   vec_t vecs [10];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(3'b010, 64'd100, 64'd7, 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 8, 1'b0, 5, 64'd14);
      vecs[1] = mk(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFD, ALL1, 65, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
      vecs[2] = mk(3'b001, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
                   64'd0, 64'd0, 0, 1'b1, 0, ALL1);
      vecs[3] = mk(3'b100, 64'h0000_0000_8000_0000, ALL1, 64'hFFFF_FFFF_8000_0000, ALL1, 1'b1,
                   64'hFFFF_FFFF_8000_0000, 64'd0, 2, 1'b0, 0, 64'hFFFF_FFFF_8000_0000);
      vecs[4] = mk(3'b111, 64'h0000_0001_0000_0005, 64'd3, 64'd5, 64'd3, 1'b0,
                   64'd1, 64'd2, 20, 1'b0, 0, 64'd2);
      vecs[5] = mk(3'b000, 64'd5, 64'd0, 64'd5, 64'd0, 1'b1, ALL1, 64'd5, 1, 1'b0, 0, ALL1);
      vecs[6] = mk(3'b001, 64'd5, 64'd0, 64'd5, 64'd0, 1'b1, 64'd0, 64'd0, 0, 1'b1, 0, 64'd5);
      vecs[7] = mk(3'b110, 64'hABCD_0000_FFFF_FFFE, 64'h1234_0000_0000_0001,
                   64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'd0,
                   5, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
      vecs[8] = mk(3'b010, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0,
                   64'h0000_0000_FFFF_FFFE, 64'd0, 3, 1'b0, 0, 64'h0000_0000_FFFF_FFFE);
      vecs[9] = mk(3'b011, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0,
                   64'd0, 64'd0, 0, 1'b1, 0, 64'd0);

      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
      resp_ready = 1'b0; flush = 1'b0; dv_out_valid = 1'b0;
      dv_quotient = '0; dv_remainder = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Flush at the tenth BUSY cycle.
      start_req(3'b010, 64'd1000, 64'd3);
      chk("fl_busy_dv_valid", {63'd0, dv_valid}, 64'd1);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("fl_dv_flush", {63'd0, dv_flush}, 64'd1);
      chk("fl_dv_valid_low", {63'd0, dv_valid}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("fl_idle_ready", {63'd0, req_ready}, 64'd1);
      chk("fl_no_resp", {63'd0, resp_valid}, 64'd0);
      chk("fl_no_dv_flush", {63'd0, dv_flush}, 64'd0);
      $display("seq flush_busy10 done");
      // Cache still holds the last completed op.
      run_vec(10, mk(3'b011, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'd0, 64'd0, 1'b0,
                     64'd0, 64'd0, 0, 1'b1, 0, 64'd0));

      // Flush colliding with divider completion: nothing captured.
      start_req(3'b010, 64'd1000, 64'd3);
      repeat (2) @(negedge clk);
      flush = 1'b1; dv_out_valid = 1'b1; dv_quotient = 64'd999; dv_remainder = 64'd9;
      @(negedge clk);
      flush = 1'b0; dv_out_valid = 1'b0; dv_quotient = '0; dv_remainder = '0;
      #1;
      chk("flcap_no_resp", {63'd0, resp_valid}, 64'd0);
      chk("flcap_idle", {63'd0, req_ready}, 64'd1);
      $display("seq flush_with_out_valid done");
      run_vec(11, mk(3'b010, 64'd1000, 64'd3, 64'd1000, 64'd3, 1'b0, 64'd333, 64'd1,
                     6, 1'b0, 0, 64'd333));
      run_vec(12, mk(3'b011, 64'd1000, 64'd3, 64'd1000, 64'd3, 1'b0, 64'd0, 64'd0,
                     0, 1'b1, 0, 64'd1));

      // Flush with a request in IDLE: not accepted.
      req_valid = 1'b1; req_op = 3'b010; req_src1 = 64'd1000; req_src2 = 64'd3; flush = 1'b1;
      #1;
      chk("flidle_ready_low", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flidle_no_resp", {63'd0, resp_valid}, 64'd0);
      chk("flidle_no_dv", {63'd0, dv_valid}, 64'd0);
      chk("flidle_ready", {63'd0, req_ready}, 64'd1);
      $display("seq flush_idle done");

      // Flush in DONE drops the response.
      start_req(3'b010, 64'd1000, 64'd3);
      chk("fldone_resp_valid", {63'd0, resp_valid}, 64'd1);
      flush = 1'b1;
      #1;
      chk("fldone_drop", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("fldone_idle", {63'd0, req_ready}, 64'd1);
      chk("fldone_no_resp", {63'd0, resp_valid}, 64'd0);
      $display("seq flush_done done");

      // Reset mid-BUSY.
      start_req(3'b010, 64'd77, 64'd5);
      chk("rst_busy_dv_valid", {63'd0, dv_valid}, 64'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk_reset_outputs("rstbusy");
      reset = 1'b0;
      @(negedge clk);
      $display("seq reset_busy done");
      // Cache was cleared by reset, so this must go to the divider.
      run_vec(13, mk(3'b011, 64'd1000, 64'd3, 64'd1000, 64'd3, 1'b0, 64'd333, 64'd1,
                     4, 1'b0, 0, 64'd1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22041752_div_ctrl.md
YSYX_22041752_DIV_CTRL -- requirements
Module: ysyx_22041752_div_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, clock; reset in 1, synchronous active-high reset; one clock domain only.
REQ-002 SHALL have pipeline request ports: req_valid in 1; req_ready out 1; req_op in 3, {word, signed_n, rem} with signed_n=1 meaning unsigned; req_src1 in 64, dividend; req_src2 in 64, divisor.
REQ-003 SHALL have response ports: resp_valid out 1; resp_ready in 1; resp_data out 64.
REQ-004 SHALL have flush in 1, which kills the in-flight operation.
REQ-005 SHALL have divider-side ports: dv_valid out 1; dv_dividend out 64; dv_divisor out 64; dv_signed out 1; dv_flush out 1; dv_out_valid in 1; dv_quotient in 64; dv_remainder in 64.

Function
REQ-006 SHALL use FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-007 IDLE: req_ready=1; on req_valid, SHALL latch op/operands and go to BUSY, or go to DONE on a cache hit (REQ-013).
REQ-008 Operand prep: word=1 SHALL extend src[31:0] to 64 bits (sign-extend if signed, zero-extend if unsigned); word=0 SHALL pass operands unchanged; dv_signed = ~signed_n.
REQ-009 BUSY: dv_valid=1; dv_dividend, dv_divisor and dv_signed SHALL stay constant from the latched copy; req_ready=0.
REQ-010 BUSY and dv_out_valid=1: SHALL capture dv_quotient and dv_remainder into the result registers, deassert dv_valid next cycle, and go to DONE.
REQ-011 Result select: rem=1 SHALL select remainder, else quotient; word=1 SHALL set resp_data = sign-extend of selected[31:0]; word=0 SHALL pass the full 64 bits.
REQ-012 DONE: resp_valid=1, resp_data held stable; on resp_ready, SHALL go to IDLE; a new request is accepted only from IDLE, with no same-cycle turnaround.
REQ-013 Result cache: after any completed divide, SHALL retain the prepared operands, dv_signed, word, quotient and remainder with cache_vld=1.
REQ-014 Cache hit: a request whose prepared operands, signedness and word bit match the cache SHALL skip the divider, go IDLE->DONE in 1 cycle, and select from the cache. This is the DIV-then-REM fusion.
REQ-015 flush in any state SHALL force IDLE next cycle and drop resp_valid.
REQ-016 flush during BUSY SHALL assert dv_flush and deassert dv_valid in the same cycle; cache contents SHALL be unchanged.
REQ-017 flush and dv_out_valid in the same cycle: flush SHALL win; no result capture and no cache update.
REQ-018 flush and req_valid in the same cycle in IDLE: SHALL not accept the request; req_ready=0.
REQ-019 Divide by zero and signed overflow SHALL be taken from the divider unmodified. The divider signals completion early in these cases, so latency varies and SHALL not be assumed to be 65 cycles.
REQ-020 Latency: cache hit, 1 cycle from accept to resp_valid; otherwise divider latency plus 1 cycle.
REQ-021 dv_valid SHALL never be high outside BUSY.

Reset
REQ-022 Reset SHALL give: state=IDLE, req_ready=1, resp_valid=0, dv_valid=0, dv_flush=0, resp_data=0, cache_vld=0.
REQ-023 Reset mid-BUSY SHALL abandon the operation; no response is produced for it.
REQ-024 Reset SHALL have priority over flush and all handshakes.

Structure
REQ-025 Op field positions (WORD, UNSIGNED, REM bit indices), FSM state encodings and the 64-bit data width SHALL be defined in the shared ysyx_22041752_mycpu.vh, using RF_DATA_WD for widths.
REQ-026 One sub-module is natural: ysyx_22041752_div_opnd_prep (combinational word extension and result select). ysyx_22041752_diver is instantiated at the level above, not inside this block.

Verification
REQ-027 DIVU 100/7 -> resp_data=14 after divider completion; dv_valid low the cycle after capture.
REQ-028 DIV -7/2, then REM -7/2 with the same operands -> 0xFFFF_FFFF_FFFF_FFFD, then -1 (0xFFFF_FFFF_FFFF_FFFF) one cycle after accept, with no dv_valid pulse.
REQ-029 DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000; REMUW 0x1_0000_0005 / 3 -> 2.
REQ-030 DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF, early completion accepted, response correct.
REQ-031 flush at BUSY cycle 10 -> dv_flush=1 that cycle, IDLE next cycle, no resp_valid; cache unchanged (same-operand request still hits only a prior completed op).
REQ-032 resp_ready held low for 5 cycles in DONE -> resp_data stable, req_ready=0 throughout; reset asserted mid-BUSY -> all outputs at reset values next cycle.
